pipe_ctrl: RTL and testbench

- Owns the ID/EX, EX/MEM and MEM/WB control pipeline registers of the 5-stage RV32I core.
- Detects load-use hazards, inserts bubbles and flushes on taken branches/jumps.
- Its registered stage instructions and write-enables are the inputs consumed by the forwarding unit and the EX operand muxes.
- Also drives stall/flush to the PC and IF/ID register.

---
 rtl/core_pkg.sv | 28 ++
 rtl/hazard_detect.sv | 31 +++
 rtl/pipe_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, write-back select encoding,
// bubble instruction and the per-stage control bundle.
package core_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wbsel_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        RegWEn;
        wbsel_e      WBSel;
        logic        MemRW;
    } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: decodes which sources the decode-stage
// instruction reads and compares them against a pending load in EX.
module hazard_detect
    import core_pkg::*;
(
    input  logic [6:0] i_opcode_id,
    input  logic [4:0] i_rs1_id,
    input  logic [4:0] i_rs2_id,
    input  logic [4:0] i_rd_ex,
    input  logic       i_regwen_ex,
    input  wbsel_e     i_wbsel_ex,
    output logic       o_lu
);

    logic w_rs1_used;
    logic w_rs2_used;
    logic w_load_ex;

    always_comb begin
        w_rs1_used = !((i_opcode_id == OP_LUI) || (i_opcode_id == OP_AUIPC) ||
                       (i_opcode_id == OP_JAL));
        w_rs2_used = (i_opcode_id == OP_R) || (i_opcode_id == OP_S) ||
                     (i_opcode_id == OP_B);
        // A load targeting x0 never produces a value anyone can wait on
        w_load_ex  = i_regwen_ex && (i_wbsel_ex == WB_MEM) && (i_rd_ex != 5'd0);
        o_lu       = w_load_ex &&
                     ((w_rs1_used && (i_rs1_id == i_rd_ex)) ||
                      (w_rs2_used && (i_rs2_id == i_rd_ex)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall, branch flush
// and memory freeze. Optional stall/flush counters under PIPE_PERF_CNT_EN.
module pipe_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W     = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_ID,
    input  logic             RegWEn_ID,
    input  logic [1:0]       WBSel_ID,
    input  logic             MemRW_ID,
    input  logic             br_taken_EX,
    input  logic             mem_busy,
    output logic [31:0]      instr_EX,
    output logic [31:0]      instr_MEM,
    output logic [31:0]      instr_WB,
    output logic             RegWEn_EX,
    output logic             RegWEn_MEM,
    output logic             RegWEn_WB,
    output logic [1:0]       WBSel_EX,
    output logic [1:0]       WBSel_MEM,
    output logic [1:0]       WBSel_WB,
    output logic             MemRW_EX,
    output logic             MemRW_MEM,
    output logic             stall_ID,
    output logic             flush_ID
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam ctrl_t BUBBLE = '{instr: NOP_INSTR, RegWEn: 1'b0, WBSel: WB_ALU, MemRW: 1'b0};

    ctrl_t r_ex, r_mem, r_wb;
    ctrl_t w_id;
    logic  w_lu;
    logic  w_kill_id;

    hazard_detect u_hazard (
        .i_opcode_id (instr_ID[6:0]),
        .i_rs1_id    (instr_ID[19:15]),
        .i_rs2_id    (instr_ID[24:20]),
        .i_rd_ex     (r_ex.instr[11:7]),
        .i_regwen_ex (r_ex.RegWEn),
        .i_wbsel_ex  (r_ex.WBSel),
        .o_lu        (w_lu)
    );

    always_comb begin
        w_id      = '{instr: instr_ID, RegWEn: RegWEn_ID, WBSel: wbsel_e'(WBSel_ID), MemRW: MemRW_ID};
        // Branch outranks load-use: the ID instruction is killed, so its hazard is moot
        w_kill_id = br_taken_EX || w_lu;
        stall_ID  = mem_busy || (!br_taken_EX && w_lu);
        flush_ID  = !mem_busy && br_taken_EX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= BUBBLE;
            r_mem <= BUBBLE;
            r_wb  <= BUBBLE;
        end else if (!mem_busy) begin
            r_ex  <= w_kill_id ? BUBBLE : w_id;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_busy) begin
            if (br_taken_EX)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            else if (w_lu)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

    assign instr_EX   = r_ex.instr;
    assign instr_MEM  = r_mem.instr;
    assign instr_WB   = r_wb.instr;
    assign RegWEn_EX  = r_ex.RegWEn;
    assign RegWEn_MEM = r_mem.RegWEn;
    assign RegWEn_WB  = r_wb.RegWEn;
    assign WBSel_EX   = r_ex.WBSel;
    assign WBSel_MEM  = r_mem.WBSel;
    assign WBSel_WB   = r_wb.WBSel;
    assign MemRW_EX   = r_ex.MemRW;
    assign MemRW_MEM  = r_mem.MemRW;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a stage-array reference model.
module tb_pipe_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADDI1  = 32'h0010_8093; // addi x1,x1,1
    localparam logic [31:0] ADD3   = 32'h0020_81B3; // add x3,x1,x2
    localparam logic [31:0] LW5    = 32'h0000_A283; // lw x5,0(x1)
    localparam logic [31:0] ADD6   = 32'h0022_8333; // add x6,x5,x2
    localparam logic [31:0] LUI6   = 32'h0000_5337; // lui x6,5
    localparam logic [31:0] LW0    = 32'h0000_A003; // lw x0,0(x1)
    localparam logic [31:0] ADD7   = 32'h0000_03B3; // add x7,x0,x0
`ifdef PIPE_PERF_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_ID;
    logic        RegWEn_ID, MemRW_ID, br_taken_EX, mem_busy;
    logic [1:0]  WBSel_ID;
    logic [31:0] instr_EX, instr_MEM, instr_WB;
    logic        RegWEn_EX, RegWEn_MEM, RegWEn_WB, MemRW_EX, MemRW_MEM;
    logic [1:0]  WBSel_EX, WBSel_MEM, WBSel_WB;
    logic        stall_ID, flush_ID;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

`ifdef PIPE_PERF_CNT_EN
    pipe_ctrl #(.CNT_W(CW)) dut (
`else
    pipe_ctrl dut (
`endif
        .clk(clk), .rst(rst), .instr_ID(instr_ID), .RegWEn_ID(RegWEn_ID),
        .WBSel_ID(WBSel_ID), .MemRW_ID(MemRW_ID), .br_taken_EX(br_taken_EX),
        .mem_busy(mem_busy), .instr_EX(instr_EX), .instr_MEM(instr_MEM),
        .instr_WB(instr_WB), .RegWEn_EX(RegWEn_EX), .RegWEn_MEM(RegWEn_MEM),
        .RegWEn_WB(RegWEn_WB), .WBSel_EX(WBSel_EX), .WBSel_MEM(WBSel_MEM),
        .WBSel_WB(WBSel_WB), .MemRW_EX(MemRW_EX), .MemRW_MEM(MemRW_MEM),
        .stall_ID(stall_ID), .flush_ID(flush_ID)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // Reference model: index 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        logic [31:0] instr;
        logic        rw;
        logic [1:0]  wb;
        logic        mw;
    } stage_t;

    stage_t        pipe[3];
    logic [CW-1:0] m_stall, m_flush;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction

    function automatic bit m_lu();
        logic [4:0] rd;
        rd = pipe[0].instr[11:7];
        if (!(pipe[0].rw && pipe[0].wb == 2'b01 && rd != 5'd0)) return 1'b0;
        return (reads_rs1(instr_ID[6:0]) && instr_ID[19:15] == rd) ||
               (reads_rs2(instr_ID[6:0]) && instr_ID[24:20] == rd);
    endfunction

    function automatic bit m_stall_exp();
        return mem_busy || (!br_taken_EX && m_lu());
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{NOP, 1'b0, 2'b00, 1'b0};
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic model_adv();
        bit lu;
        lu = m_lu();
        if (!mem_busy) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (br_taken_EX || lu) begin
                pipe[0] = '{NOP, 1'b0, 2'b00, 1'b0};
                if (br_taken_EX) m_flush = m_flush + 1'b1;
                else             m_stall = m_stall + 1'b1;
            end else begin
                pipe[0] = '{instr_ID, RegWEn_ID, WBSel_ID, MemRW_ID};
            end
        end
    endtask

    task automatic check_all();
        chk("instr_EX",   instr_EX,   pipe[0].instr);
        chk("instr_MEM",  instr_MEM,  pipe[1].instr);
        chk("instr_WB",   instr_WB,   pipe[2].instr);
        chk("RegWEn_EX",  {31'd0, RegWEn_EX},  {31'd0, pipe[0].rw});
        chk("RegWEn_MEM", {31'd0, RegWEn_MEM}, {31'd0, pipe[1].rw});
        chk("RegWEn_WB",  {31'd0, RegWEn_WB},  {31'd0, pipe[2].rw});
        chk("WBSel_EX",   {30'd0, WBSel_EX},   {30'd0, pipe[0].wb});
        chk("WBSel_MEM",  {30'd0, WBSel_MEM},  {30'd0, pipe[1].wb});
        chk("WBSel_WB",   {30'd0, WBSel_WB},   {30'd0, pipe[2].wb});
        chk("MemRW_EX",   {31'd0, MemRW_EX},   {31'd0, pipe[0].mw});
        chk("MemRW_MEM",  {31'd0, MemRW_MEM},  {31'd0, pipe[1].mw});
        chk("stall_ID",   {31'd0, stall_ID},   {31'd0, m_stall_exp()});
        chk("flush_ID",   {31'd0, flush_ID},   {31'd0, !mem_busy && br_taken_EX});
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt",  32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt",  32'(flush_cnt), 32'(m_flush));
`endif
    endtask

    // Compare mid-cycle, then advance model with the DUT edge; returns at posedge+1
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic set_id(input logic [31:0] ins, input logic rw, input logic [1:0] wb, input logic mw);
        instr_ID  = ins;
        RegWEn_ID = rw;
        WBSel_ID  = wb;
        MemRW_ID  = mw;
    endtask

    // Present an instruction in ID and hold it until accepted; n = cycles spent
    task automatic issue(input logic [31:0] ins, input logic rw, input logic [1:0] wb,
                         input logic mw, output int n);
        bit s;
        set_id(ins, rw, wb, mw);
        n = 0;
        do begin
            s = m_stall_exp();
            step();
            n++;
        end while (s && n < 8);
        if (s) chk("issue_timeout", 32'(n), 32'd0);
    endtask

    int n;
    logic [CW-1:0] sv_stall, sv_flush;

    initial begin
        rst = 1'b1;
        set_id(NOP, 1'b0, 2'b00, 1'b0);
        br_taken_EX = 1'b0;
        mem_busy    = 1'b0;
        model_reset();
        #3;
        check_all();
        chk("reset_instr_WB", instr_WB, NOP);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Load-use: exactly one bubble
        issue(ADDI1, 1'b1, 2'b00, 1'b0, n);
        issue(ADD3,  1'b1, 2'b00, 1'b0, n);
        issue(LW5,   1'b1, 2'b01, 1'b0, n);
        issue(ADD6,  1'b1, 2'b00, 1'b0, n);
        chk("lu_cycles",     32'(n), 32'd2);
        chk("lu_add_in_EX",  instr_EX, ADD6);
        chk("lu_bubble_MEM", instr_MEM, NOP);
        chk("lu_bubble_wen", {31'd0, RegWEn_MEM}, 32'd0);
        chk("lu_lw_in_WB",   instr_WB, LW5);

        // No hazard: lui after load, and x0 load
        issue(LW5,  1'b1, 2'b01, 1'b0, n);
        issue(LUI6, 1'b1, 2'b00, 1'b0, n);
        chk("lui_no_stall", 32'(n), 32'd1);
        issue(LW0,  1'b1, 2'b01, 1'b0, n);
        issue(ADD7, 1'b1, 2'b00, 1'b0, n);
        chk("x0_no_stall", 32'(n), 32'd1);

        // Branch while load-use pending: flush wins
        issue(LW5, 1'b1, 2'b01, 1'b0, n);
        set_id(ADD6, 1'b1, 2'b00, 1'b0);
        br_taken_EX = 1'b1;
        #1;
        chk("br_flush_ID", {31'd0, flush_ID}, 32'd1);
        chk("br_stall_ID", {31'd0, stall_ID}, 32'd0);
        sv_stall = m_stall;
        sv_flush = m_flush;
        step();
        br_taken_EX = 1'b0;
        chk("br_EX_nop", instr_EX, NOP);
        chk("br_lw_MEM", instr_MEM, LW5);
`ifdef PIPE_PERF_CNT_EN
        chk("br_flush_cnt", 32'(flush_cnt), 32'(sv_flush + 1'b1));
        chk("br_stall_cnt", 32'(stall_cnt), 32'(sv_stall));
`endif

        // Memory freeze for three cycles mid-flow
        issue(ADDI1, 1'b1, 2'b00, 1'b0, n);
        issue(ADD3,  1'b1, 2'b00, 1'b1, n);
        set_id(LW5, 1'b1, 2'b01, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("busy_EX_held",  instr_EX,  ADD3);
        chk("busy_MEM_held", instr_MEM, ADDI1);
        chk("busy_stall",    {31'd0, stall_ID}, 32'd1);
        mem_busy = 1'b0;
        issue(LW5, 1'b1, 2'b01, 1'b0, n);
        chk("resume_EX",  instr_EX,  LW5);
        chk("resume_MEM", instr_MEM, ADD3);
        chk("resume_WB",  instr_WB,  ADDI1);

        // Asynchronous reset mid-run
        set_id(ADD3, 1'b1, 2'b00, 1'b0);
        step();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("arst_EX",  instr_EX, NOP);
        chk("arst_wen", {31'd0, RegWEn_EX}, 32'd0);
        #1 rst = 1'b0;
        issue(ADD3, 1'b1, 2'b00, 1'b0, n);
        chk("post_rst_EX", instr_EX, ADD3);
        set_id(NOP, 1'b0, 2'b00, 1'b0);
        step();
        step();
        chk("post_rst_WB", instr_WB, ADD3);

`ifdef PIPE_PERF_CNT_EN
        // Counter wrap: 17 load-use events into a 4-bit counter
        #1 rst = 1'b1;
        #1 model_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            issue(LW5,  1'b1, 2'b01, 1'b0, n);
            issue(ADD6, 1'b1, 2'b00, 1'b0, n);
        end
        chk("wrap_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("wrap_flush_cnt", 32'(flush_cnt), 32'd0);
`endif

        set_id(NOP, 1'b0, 2'b00, 1'b0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
